// File: rtl/softmax_pkg.sv
// Shared widths, FSM states and exp-approximation constants
// for the approximate-softmax datapath.
package softmax_pkg;

    localparam int LOGIT_W = 8;
    localparam int EXP_W   = 8;
    localparam int SUM_W   = 32;
    localparam int D_W     = 9;
    localparam int T_W     = 10;

    localparam int K_MAX     = 9;
    localparam int MANT_STEP = 8;
    localparam logic [D_W-1:0] MANT_ONE = 9'd256;

    typedef enum logic [1:0] {
        LOAD,
        EXP,
        EMIT
    } state_t;

endpackage

// File: rtl/softmax_exp_stage_exp2_approx.sv
// Combinational shift-and-subtract approximation of
// e^(-d) for a Q5.4 distance d, giving an unsigned Q0.8 result.
module exp2_approx
    import softmax_pkg::*;
(
    input  logic [D_W-1:0]   d,
    output logic [EXP_W-1:0] e
);

    logic [T_W-1:0] t;
    logic [5:0]     k;
    logic [3:0]     f;
    logic [D_W-1:0] mant;
    logic [D_W-1:0] sh;

    // t ~= d * log2(e): d + d/2 - d/16
    assign t    = {1'b0, d} + {2'b0, d[D_W-1:1]} - {5'b0, d[D_W-1:4]};
    assign k    = t[T_W-1:4];
    assign f    = t[3:0];
    assign mant = MANT_ONE - D_W'(f * MANT_STEP);
    assign sh   = mant >> k;

    always_comb begin
        e = '0;
        if (k < 6'(K_MAX)) begin
            e = (sh > 9'd255) ? 8'hFF : sh[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/softmax_exp_stage.sv
// Buffers a logit vector, finds its max, converts each element to
// exp(x - max) in place, then streams (exp, sum) pairs downstream.
module softmax_exp_stage
    import softmax_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LOGIT_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_exp,
    output logic [SUM_W-1:0]   out_sum,
    output logic               out_last,
    output logic               busy
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic signed [LOGIT_W-1:0] MAX_INIT = -8'sd128;

    state_t state_q, state_d;
    logic [LOGIT_W-1:0] mem_q [N];
    logic [AW-1:0] idx_q;
    logic signed [LOGIT_W-1:0] max_q;
    logic [SUM_W-1:0] sum_q;

    logic [LOGIT_W-1:0] cur;
    logic [D_W-1:0] d;
    logic [EXP_W-1:0] e;
    logic at_last;
    logic accept, step, emit_hs;

    assign cur     = mem_q[idx_q];
    assign at_last = (idx_q == LAST);
    // max >= every element, so the 9-bit difference is non-negative
    assign d = {max_q[LOGIT_W-1], max_q} - {cur[LOGIT_W-1], cur};

    exp2_approx u_exp (
        .d (d),
        .e (e)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        emit_hs = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (at_last) state_d = EXP;
                end
            end
            EXP: begin
                step = 1'b1;
                if (at_last) state_d = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    emit_hs = 1'b1;
                    if (at_last) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EXP) || (state_q == EMIT);
    assign out_last  = out_valid && at_last;
    assign out_exp   = cur;
    assign out_sum   = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            max_q   <= MAX_INIT;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept || step || emit_hs) begin
                idx_q <= at_last ? '0 : idx_q + AW'(1);
            end
            if (accept) begin
                if ($signed(in_data) > max_q) max_q <= $signed(in_data);
                if (at_last) sum_q <= '0;
            end
            if (step) sum_q <= sum_q + SUM_W'(e);
            if (emit_hs && at_last) max_q <= MAX_INIT;
        end
    end

    // Buffer content is don't-care after reset, so it carries none
    always_ff @(posedge clk) begin
        if (accept) mem_q[idx_q] <= in_data;
        else if (step) mem_q[idx_q] <= e;
    end

endmodule

// File: tb/tb_softmax_exp_stage.sv
// Directed and randomized checks of softmax_exp_stage
// against an integer model of the exp approximation.
module tb_softmax_exp_stage;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_exp;
  logic [31:0] out_sum;
  logic        out_last;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int vec   [N];
  int exp_m [N];
  int sum_m;

  softmax_exp_stage #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, expv);
    end
  endtask

  function automatic int ref_exp(int d);
    int t, k, f, m;
    t = d + d / 2 - d / 16;
    k = t / 16;
    f = t % 16;
    m = 256 - 8 * f;
    if (k >= 9) return 0;
    m = m / (1 << k);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic void build_model();
    int mx = -128;
    foreach (vec[i]) if (vec[i] > mx) mx = vec[i];
    sum_m = 0;
    foreach (vec[i]) begin
      exp_m[i] = ref_exp(mx - vec[i]);
      sum_m += exp_m[i];
    end
  endfunction

  task automatic load_vec(input bit gaps, input bit hold);
    bit acc;
    int cyc;
    for (int i = 0; i < N; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 8'(vec[i]);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 100) begin
        acc = in_ready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!acc) begin
        n_fail++;
        $error("FAIL load wait expired at %0d", i);
      end
      chk("load_accept", acc, 1'b1);
    end
    if (hold) in_data = 8'($urandom);
    else in_valid = 1'b0;
  endtask

  task automatic wait_latency(input bit hold);
    int cnt = 1;
    chk("busy_exp", busy, 1'b1);
    chk("in_ready_exp", in_ready, 1'b0);
    while (!out_valid && cnt < 100) begin
      if (hold) in_data = 8'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    n_assert++;
    if (!out_valid) begin
      n_fail++;
      $error("FAIL out_valid wait expired");
    end
    chk("latency", cnt, N + 1);
  endtask

  task automatic drain(input int stall_idx,
                       input bit rnd, input bit hold);
    int j = 0;
    int cyc = 0;
    int stalled = 0;
    bit hs;
    while (j < N && cyc < 1000) begin
      if (j == stall_idx && stalled < 3) begin
        out_ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (hold) in_data = 8'($urandom);
      if (out_valid) begin
        chk("out_exp", out_exp, exp_m[j]);
        chk("out_sum", out_sum, sum_m);
        chk("out_last", out_last, (j == N - 1));
        if (hold) chk("in_ready_emit", in_ready, 1'b0);
      end
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      if (hs) j++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("pairs_delivered", j, N);
    chk("back_to_load", in_ready, 1'b1);
    chk("valid_drop", out_valid, 1'b0);
  endtask

  task automatic run_vec(input bit gaps, input bit hold,
                         input int stall_idx, input bit rnd);
    build_model();
    load_vec(gaps, hold);
    wait_latency(hold);
    drain(stall_idx, rnd, hold);
  endtask

  initial begin
    #12;
    n_assert++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      n_fail++;
      $error("FAIL reset state: v=%b r=%b b=%b",
             out_valid, in_ready, busy);
    end
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_sum", out_sum, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vec[i]) vec[i] = 32;
    run_vec(1'b0, 1'b0, -1, 1'b0);
    chk("sum_all_equal", out_sum, 4080);

    foreach (vec[i]) vec[i] = 0;
    vec[3] = 16;
    run_vec(1'b0, 1'b0, -1, 1'b0);
    chk("sum_one_high", out_sum, 1755);

    foreach (vec[i]) vec[i] = -128;
    vec[0] = 127;
    run_vec(1'b0, 1'b0, -1, 1'b0);
    chk("sum_extreme", out_sum, 255);

    foreach (vec[i]) vec[i] = $urandom_range(0, 255) - 128;
    run_vec(1'b0, 1'b0, 5, 1'b0);

    for (int r = 0; r < 4; r++) begin
      foreach (vec[i]) vec[i] = $urandom_range(0, 80) - 40;
      run_vec(1'b1, 1'b0, -1, 1'b1);
    end

    foreach (vec[i]) vec[i] = 32;
    load_vec(1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vec[i]) vec[i] = 0;
    run_vec(1'b0, 1'b0, -1, 1'b0);
    chk("sum_after_abort", out_sum, 4080);

    foreach (vec[i]) vec[i] = $urandom_range(0, 255) - 128;
    run_vec(1'b0, 1'b1, -1, 1'b0);
    foreach (vec[i]) vec[i] = $urandom_range(0, 255) - 128;
    run_vec(1'b0, 1'b0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
